// File: rtl/jpeg_blk_arbiter.sv
// jpeg_blk_arbiter: block-granular round-robin arbiter that shares one JPEG
// coefficient datapath between NUM_REQ component streams. A grant is held for
// exactly BLK_LEN accepted beats so blocks from different streams never
// interleave. Framing (first/last), source tags and block-done pulses are
// generated here.
module jpeg_blk_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 12,
    parameter int BLK_LEN = 64,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      dp_valid,
    output logic [DATA_W-1:0]         dp_data,
    output logic [SRC_W-1:0]          dp_src,
    output logic                      dp_first,
    output logic                      dp_last,
    input  logic                      dp_ready,
    input  logic                      flush,
    output logic                      busy,
    output logic                      blk_done,
    output logic [SRC_W-1:0]          blk_done_src
);

    localparam int                CNT_W     = $clog2(BLK_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BLK_LEN - 1);
    localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NUM_REQ - 1);
    localparam logic [SRC_W:0]    NUM_REQ_W = (SRC_W+1)'(NUM_REQ);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_next;
    logic [SRC_W-1:0]   grant, grant_next;
    logic [SRC_W-1:0]   rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
    logic               done_next;
    logic [SRC_W-1:0]   done_src_next;
    logic [SRC_W-1:0]   grant_inc;
    logic               pick_found;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W:0]     cand;
    logic               accept;

    assign grant_inc = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!pick_found && req_valid[cand[SRC_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[SRC_W-1:0];
            end
        end
    end

    // Next-state and output logic: IDLE arbitrates, BURST forwards the granted stream and counts beats.
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        done_next     = 1'b0;
        done_src_next = blk_done_src;
        req_ready     = '0;
        dp_valid      = 1'b0;
        dp_data       = '0;
        dp_src        = '0;
        dp_first      = 1'b0;
        dp_last       = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && pick_found) begin
                    grant_next    = pick;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                busy             = 1'b1;
                dp_valid         = req_valid[grant];
                dp_data          = req_data[int'(grant)*DATA_W +: DATA_W];
                dp_src           = grant;
                dp_first         = (beat_cnt == '0);
                dp_last          = (beat_cnt == LAST_BEAT);
                req_ready[grant] = dp_ready;
                accept           = dp_valid & dp_ready;
                if (flush) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                    rr_ptr_next   = grant_inc;
                end else if (accept) begin
                    if (dp_last) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                        rr_ptr_next   = grant_inc;
                        done_next     = 1'b1;
                        done_src_next = grant;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset drops any block in flight without reporting it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            blk_done     <= 1'b0;
            blk_done_src <= '0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            rr_ptr       <= rr_ptr_next;
            beat_cnt     <= beat_cnt_next;
            blk_done     <= done_next;
            blk_done_src <= done_src_next;
        end
    end

endmodule

// File: doc/jpeg_blk_arbiter.md
Name: jpeg_blk_arbiter

Overview:
- Block-granular round-robin arbiter that shares one JPEG coefficient datapath (quantizer/entropy timing cone) between NUM_REQ component streams (Y, Cb, Cr).
- Each grant is locked for exactly BLK_LEN accepted beats, so an 8x8 block is never interleaved with another stream.
- The arbiter sits between the component buffers and the shared datapath. It generates first/last framing and source tags for the datapath and pulses block completion back to the scheduler.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 12, coefficient width in bits.
- BLK_LEN, 64, beats per block (power of two, 2..256).
- SRC_W, 2, width of source id; must satisfy 2^SRC_W >= NUM_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  per-requester coefficient; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester beat accept.
- dp_valid  out  1  beat valid to datapath.
- dp_data  out  DATA_W  coefficient to datapath.
- dp_src  out  SRC_W  id of the granted requester.
- dp_first  out  1  beat is index 0 of the block.
- dp_last  out  1  beat is index BLK_LEN-1.
- dp_ready  in  1  datapath accept.
- flush  in  1  synchronous abort of the current block.
- busy  out  1  a grant is held.
- blk_done  out  1  one-cycle pulse after a block completes.
- blk_done_src  out  SRC_W  source of the completed block; valid while blk_done=1.

Behaviour:
- Reset is asynchronous and active-high (rst) with a single clock (clk).
  - Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, grant=0.
  - Output reset values: busy=0, blk_done=0, blk_done_src=0, req_ready=0, dp_valid=0, dp_first=0, dp_last=0, dp_src=0, dp_data=0.
- States: IDLE and BURST.
- IDLE:
  - req_ready=0, dp_valid=0.
  - If any req_valid is high, pick the first requester with valid high, searching from rr_ptr upward modulo NUM_REQ.
  - Register it as grant, set beat_cnt=0 and go to BURST on the next edge.
  - This gives exactly one bubble cycle of arbitration latency.
- BURST, combinational path:
  - dp_valid = req_valid[grant].
  - dp_data = req_data[grant].
  - dp_src = grant.
  - req_ready[grant] = dp_ready; all other ready bits are 0.
  - dp_first = (beat_cnt==0).
  - dp_last = (beat_cnt==BLK_LEN-1).
  - busy=1.
- Accepted beat: dp_valid & dp_ready.
  - Increments beat_cnt (width clog2(BLK_LEN)).
  - If dp_last is also set, the beat completes the block:
    - beat_cnt wraps to 0.
    - rr_ptr = (grant+1) mod NUM_REQ.
    - Next state IDLE.
    - blk_done=1 and blk_done_src=grant on the following cycle.
- Stalls: while the granted requester drops valid mid-block, the grant is held indefinitely and beat_cnt is frozen. Other requesters are never granted mid-block.
- dp_valid is not required to stay high under dp_ready=0 (requester-owned). dp_data and framing are stable while dp_valid=1 and dp_ready=0, because beat_cnt does not advance.
- flush:
  - Flush in BURST: next state IDLE, beat_cnt=0, rr_ptr = (grant+1) mod NUM_REQ, no blk_done.
  - Flush in IDLE: ignored; the arbitration in that cycle is suppressed.
  - Flush coincident with a last-beat accept: the beat is accepted (ready stays combinational), but blk_done is suppressed.
- Reset mid-burst: the state is lost immediately and all outputs go to their reset values asynchronously. Beats in flight are not reported.
- No requester valid: the block stays in IDLE and rr_ptr is unchanged.
- BLK_LEN=2 boundary: dp_first and dp_last fall on consecutive beats.
- dp_first and dp_last are never both high unless BLK_LEN=1, which is disallowed.

Test Plan:
- Single requester: assert rst, release; hold req_valid=3'b001 with dp_ready=1.
  - First beat appears 1 cycle after release with dp_first=1 and dp_src=0.
  - 64 beats follow, dp_last on the 64th.
  - blk_done=1 with blk_done_src=0 on the next cycle.
  - Re-grant to requester 0 occurs after one IDLE cycle.
- Round-robin: all three valid continuously with dp_ready=1.
  - Grant order is 0,1,2,0.
  - Each burst is 64 beats separated by one IDLE bubble.
  - Each blk_done_src matches the grant.
- Backpressure: toggle dp_ready every other cycle.
  - dp_data and dp_first/dp_last hold while ready is 0.
  - Exactly 64 accepts per block, completing after 128 cycles.
- Valid stall: requester 1 drops valid at beat 20 for 10 cycles while requester 2 is valid.
  - No switch to requester 2; beat_cnt resumes at 20; the block completes with 64 beats from source 1.
- Flush at beat 30 of requester 0's block.
  - No blk_done.
  - The next grant goes to requester 1 and its first beat has dp_first=1.
- Async reset at beat 40.
  - All outputs are 0 within the same cycle.
  - After release, the grant starts at requester 0 (rr_ptr=0) with beat_cnt 0.
